// File: rtl/arbitro_param.sv
// arbitro_param: dispatches words from one show-ahead input FIFO to NUM_CH output FIFOs,
// choosing the output by back-pressure-aware round-robin or by the word's destination field.
module arbitro_param #(
   parameter int DATA_WIDTH = 10,
   parameter int CH_BITS = 2,
   parameter logic [3:0] IDLE_STATE = 4'b0001,
   localparam int NUM_CH = 2**CH_BITS
) (
   input logic clk,
   input logic reset_L,
   input logic [3:0] state,
   input logic route_mode,
   input logic empty,
   input logic [DATA_WIDTH-1:0] data_in,
   input logic [NUM_CH-1:0] almost_full,
   output logic pop,
   output logic [NUM_CH-1:0] push,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic stall
);
   logic [CH_BITS-1:0] rr_ptr, rr_tgt, dst, tgt;
   logic rr_ok, ok, idle, active;
   // scanning downward lets the channel closest to rr_ptr win
   always_comb begin
      rr_tgt = rr_ptr;
      rr_ok = 1'b0;
      for (int i = NUM_CH-1; i >= 0; i--)
         if (!almost_full[rr_ptr + CH_BITS'(i)]) begin
            rr_tgt = rr_ptr + CH_BITS'(i);
            rr_ok = 1'b1;
         end
   end
   assign dst = data_in[DATA_WIDTH-1 -: CH_BITS];
   assign tgt = route_mode ? dst : rr_tgt;
   assign ok = route_mode ? !almost_full[dst] : rr_ok;
   assign idle = state == IDLE_STATE;
   assign active = reset_L && !idle && !empty;
   assign pop = active && ok;
   always_ff @(posedge clk or negedge reset_L)
      if (!reset_L) begin
         rr_ptr <= '0;
         push <= '0;
         data_out <= '0;
         stall <= 1'b0;
      end else begin
         push <= pop ? NUM_CH'(1) << tgt : '0;
         if (pop) data_out <= data_in;
         stall <= active && !pop;
         rr_ptr <= idle ? '0 : (pop && !route_mode) ? tgt + CH_BITS'(1) : rr_ptr;
      end
endmodule

// File: doc/arbitro_param.md
# arbitro_param

Parametrised dispatch arbiter between the shared input FIFO and NUM_CH output FIFOs. It pops words from the input FIFO and pushes each word to one output FIFO. The output is chosen by back-pressure-aware round-robin or by a destination field in the word. It sits after the main control FSM and replaces the fixed 4-output, round-robin-only arbiter.

## Interface
- DATA_WIDTH, 10, word width; the destination field is the top CH_BITS bits.
- CH_BITS, 2, channel index width; NUM_CH = 2**CH_BITS, legal CH_BITS 1..3.
- IDLE_STATE, 4'b0001, encoding of the FSM idle state.
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous, active-low reset.
- state  input  4  control FSM state; arbitration is disabled while state == IDLE_STATE.
- route_mode  input  1  0 = round-robin, 1 = destination-routed.
- empty  input  1  input FIFO empty.
- data_in  input  DATA_WIDTH  head word of the show-ahead input FIFO, valid when empty == 0.
- almost_full  input  NUM_CH  per-output-FIFO almost-full flags.
- pop  output  1  input FIFO read strobe (combinational).
- push  output  NUM_CH  one-hot output FIFO write strobes (registered).
- data_out  output  DATA_WIDTH  word written to the output FIFOs (registered, shared bus).
- stall  output  1  registered; high when a word was waiting but could not be dispatched.

## Operation
- Internal registers:
  - rr_ptr: CH_BITS wide, next round-robin start channel.
  - push, data_out, stall.
- Eligibility: active = reset_L && (state != IDLE_STATE) && !empty.
- Target selection, round-robin (route_mode = 0):
  - Scan channels rr_ptr, rr_ptr+1, … modulo NUM_CH, wrapping naturally in CH_BITS.
  - The first channel with almost_full == 0 is the target.
  - If all channels are almost full, there is no target.
- Target selection, destination-routed (route_mode = 1):
  - target = data_in[DATA_WIDTH-1 -: CH_BITS].
  - If almost_full[target] == 1, there is no target. This is strict head-of-line blocking; no other channel is served.
- pop = active && target exists. It is combinational and has exactly one pulse per transferred word.
- On a clk edge with pop == 1:
  - push <= one-hot(target).
  - data_out <= data_in, with the full word including the destination field.
  - In round-robin mode only, rr_ptr <= target + 1 (mod NUM_CH).
- On a clk edge with pop == 0:
  - push <= 0.
  - data_out holds its value.
- stall <= active && !pop.
- While state == IDLE_STATE:
  - pop = 0.
  - rr_ptr <= 0 on each edge.
  - push <= 0.
  - Any word already registered still completes its push on the first idle edge. No transfer is lost or duplicated.
- In destination mode, rr_ptr holds its value.
- A change of route_mode takes effect on the next target evaluation. No word is dropped or duplicated.
- Invariant: push is always zero or one-hot. The count of pushes equals the count of pops, offset by at most one in flight.

## Timing
- Reset (reset_L low, asynchronous): push = 0, data_out = 0, stall = 0, rr_ptr = 0, pop = 0.
- Release of reset_L is recognised at the first clk edge after release.
- Latency: pop in cycle N, then push/data_out valid in cycle N+1, for exactly one cycle per word.
- Throughput: one word per cycle when the input is non-empty and a target is available.
- Back-pressure:
  - almost_full is sampled combinationally in the same cycle as pop.
  - Output FIFOs must assert almost_full with at least 1 free entry so that the in-flight push fits.
- Simultaneous events:
  - empty rising in the same cycle means no pop.
  - almost_full[target] rising in the same cycle re-targets (RR) or blocks (dest).
- Reset asserted mid-transfer: the pending push is discarded and the popped word is lost. This is acceptable; the upstream FSM re-initialises.

## Test plan
- Reset then RR, NUM_CH=4, 8 words 0x001..0x008, no almost_full:
  - pop high 8 cycles.
  - push sequence 0001,0010,0100,1000,0001,… one cycle later.
  - data_out matches in order.
- RR skip: almost_full = 4'b0010 constant, 4 words:
  - pushes go to channels 0,2,3,0.
  - stall stays 0.
- RR all full: almost_full = 4'b1111 with empty = 0 for 3 cycles:
  - pop = 0, push = 0, stall = 1.
  - When almost_full clears to 0, the next push goes to the rr_ptr channel saved before the block.
- Destination mode, DATA_WIDTH=10: words 0x3AA, 0x155, 0x0FF:
  - pushes go to channels 3, 1, 0.
  - Set almost_full[2]=1 and present head word 0x2xx: no pop and stall = 1 until it clears.
  - Channel 0 is not served meanwhile.
- Idle entry: state goes to IDLE_STATE in the cycle after a pop:
  - The in-flight push completes.
  - pop stays 0 while empty = 0.
  - rr_ptr = 0; the first push after leaving idle goes to channel 0.
- Async reset mid-stream:
  - Drop reset_L between edges while a push is pending.
  - push, data_out and stall go to 0 immediately, without a clock edge.
